// File: rtl/pixel_data_parse.sv
// rtl/pixel_data_parse.sv - pixel-stream frame parser: SOF/header check, payload reassembly, EOF check
// Define PIXEL_PARSE_ERR_CNT_EN to add the saturating err_cnt output.
module pixel_data_parse #(
  parameter int unsigned DLEN      = 32'h002b,
  parameter int unsigned HDR_WORDS = 2,
  parameter logic [7:0]  PHL_ID    = 8'h00,
  parameter logic [7:0]  DTYPE     = 8'h01
) (
  input  logic              rx_pixel_clk,
  input  logic              rstn,
  input  logic              pixel_valid,
  input  logic [63:0]       pixel_value,
  output logic [DLEN*8-1:0] data,
  output logic              data_valid,
  output logic              frame_err,
  output logic              busy
`ifdef PIXEL_PARSE_ERR_CNT_EN
  ,
  output logic [15:0]       err_cnt
`endif
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR  = 3'd1;
  localparam logic [2:0] S_PAY  = 3'd2;
  localparam logic [2:0] S_EOF2 = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [31:0] DLEN_W   = 32'(DLEN);
  localparam int unsigned NFULL    = DLEN / 6;
  localparam int unsigned REM      = DLEN % 6;
  localparam logic [9:0]  K_TAIL   = 10'(NFULL * 6);
  localparam logic [2:0]  REM_LEN  = 3'(REM);
  localparam logic [2:0]  IDX_AA   = 3'(REM);
  localparam logic [2:0]  IDX_DD   = 3'(REM + 1);
  localparam logic [1:0]  HDR_LAST = 2'(HDR_WORDS - 1);

  localparam logic [47:0] SOF_W = {8'h01, 24'h000000, 16'hFFEA};
  localparam logic [47:0] HDR_W = {PHL_ID, DLEN_W[7:0], DLEN_W[15:8],
                                   DLEN_W[23:16], DLEN_W[31:24], DTYPE};

  logic [2:0]        state_q, state_d;
  logic [9:0]        k_q, k_d;
  logic [1:0]        hcnt_q, hcnt_d;
  logic [DLEN*8-1:0] data_q, data_d;
  logic              dv_q, dv_d;
  logic              ferr_q, ferr_d;
  logic              busy_q, busy_d;
  logic              fail;
  logic              wr_en;
  logic [2:0]        wr_len;
  logic [47:0]       w;
  logic [7:0]        wb [8];
  logic              unused_hi;

  assign w         = pixel_value[47:0];
  assign unused_hi = &{1'b0, pixel_value[63:48]};

  // Two spare zero lanes keep the EOF byte lookups in range for every REM.
  always_comb begin
    for (int i = 0; i < 6; i++) begin
      wb[i] = w[i*8 +: 8];
    end
    wb[6] = 8'h00;
    wb[7] = 8'h00;
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    hcnt_d  = hcnt_q;
    busy_d  = busy_q;
    dv_d    = 1'b0;
    ferr_d  = 1'b0;
    fail    = 1'b0;
    wr_en   = 1'b0;
    wr_len  = 3'd6;
    case (state_q)
      S_IDLE: begin
        if (pixel_valid && (w == SOF_W)) begin
          state_d = S_HDR;
          busy_d  = 1'b1;
          hcnt_d  = 2'd0;
        end
      end
      S_HDR: begin
        if (pixel_valid) begin
          if (w == HDR_W) begin
            if (hcnt_q == HDR_LAST) begin
              state_d = S_PAY;
              k_d     = 10'd0;
              hcnt_d  = 2'd0;
            end else begin
              hcnt_d = hcnt_q + 2'd1;
            end
          end else if (w == SOF_W) begin
            hcnt_d = 2'd0;
          end else begin
            fail = 1'b1;
          end
        end
      end
      S_PAY: begin
        if (pixel_valid) begin
          wr_en = 1'b1;
          if (k_q < K_TAIL) begin
            k_d = k_q + 10'd6;
          end else begin
            wr_len = REM_LEN;
            if (REM == 5) begin
              if (wb[5] == 8'hAA) state_d = S_EOF2;
              else                fail    = 1'b1;
            end else if ((wb[IDX_AA] == 8'hAA) && (wb[IDX_DD] == 8'hDD)) begin
              state_d = S_DONE;
            end else begin
              fail = 1'b1;
            end
          end
        end
      end
      S_EOF2: begin
        if (pixel_valid) begin
          if (wb[0] == 8'hDD) state_d = S_DONE;
          else                fail    = 1'b1;
        end
      end
      S_DONE: begin
        dv_d    = 1'b1;
        busy_d  = 1'b0;
        k_d     = 10'd0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (fail) begin
      ferr_d  = 1'b1;
      state_d = S_IDLE;
      busy_d  = 1'b0;
      k_d     = 10'd0;
      hcnt_d  = 2'd0;
    end
  end

  // Each payload byte lane picks its source byte from the current word by offset from k.
  always_comb begin
    logic [10:0] bi;
    logic [10:0] off;
    data_d = data_q;
    bi     = 11'd0;
    off    = 11'd0;
    for (int b = 0; b < int'(DLEN); b++) begin
      bi  = 11'(b);
      off = bi - {1'b0, k_q};
      if (wr_en && (bi >= {1'b0, k_q}) && (off < {8'd0, wr_len})) begin
        data_d[b*8 +: 8] = wb[off[2:0]];
      end
    end
  end

  always_ff @(posedge rx_pixel_clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      hcnt_q  <= '0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      hcnt_q  <= hcnt_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
    end
  end

  assign data       = data_q;
  assign data_valid = dv_q;
  assign frame_err  = ferr_q;
  assign busy       = busy_q;

`ifdef PIXEL_PARSE_ERR_CNT_EN
  logic [15:0] err_cnt_q;

  always_ff @(posedge rx_pixel_clk or negedge rstn) begin
    if (!rstn) begin
      err_cnt_q <= '0;
    end else if (ferr_d && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_pixel_data_parse.sv
// tb/tb_pixel_data_parse.sv - randomized frame stimulus against a frame-level expectation model
// Three parser instances cover REM = 1, 5 and 0; err_cnt checked when PIXEL_PARSE_ERR_CNT_EN is defined.
module tb_pixel_data_parse;

  localparam logic [47:0] SOF = {8'h01, 24'h000000, 16'hFFEA};
  localparam int BIG = 32'h7fffffff;

  logic           clk = 1'b0;
  logic           rstn;
  logic           pv [3];
  logic [63:0]    pw [3];
  logic [43*8-1:0] data43;
  logic [11*8-1:0] data11;
  logic [12*8-1:0] data12;
  logic [2:0]     dv_o, fe_o, bz_o;
`ifdef PIXEL_PARSE_ERR_CNT_EN
  logic [15:0]    ec_o [3];
`endif

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  bit run = 1'b0;
  int exp_dv [3];
  int exp_fe [3];
  int busy_on [3];
  int busy_off [3];
  int ec_model [3];
  int dv_cnt [3];
  logic [7:0] mb [3][1024];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pixel_data_parse #(.DLEN(43), .HDR_WORDS(2), .PHL_ID(8'h00), .DTYPE(8'h01)) u43 (
    .rx_pixel_clk(clk), .rstn(rstn), .pixel_valid(pv[0]), .pixel_value(pw[0]),
    .data(data43), .data_valid(dv_o[0]), .frame_err(fe_o[0]), .busy(bz_o[0])
`ifdef PIXEL_PARSE_ERR_CNT_EN
    , .err_cnt(ec_o[0])
`endif
  );

  pixel_data_parse #(.DLEN(11), .HDR_WORDS(2), .PHL_ID(8'h00), .DTYPE(8'h01)) u11 (
    .rx_pixel_clk(clk), .rstn(rstn), .pixel_valid(pv[1]), .pixel_value(pw[1]),
    .data(data11), .data_valid(dv_o[1]), .frame_err(fe_o[1]), .busy(bz_o[1])
`ifdef PIXEL_PARSE_ERR_CNT_EN
    , .err_cnt(ec_o[1])
`endif
  );

  pixel_data_parse #(.DLEN(12), .HDR_WORDS(2), .PHL_ID(8'h00), .DTYPE(8'h01)) u12 (
    .rx_pixel_clk(clk), .rstn(rstn), .pixel_valid(pv[2]), .pixel_value(pw[2]),
    .data(data12), .data_valid(dv_o[2]), .frame_err(fe_o[2]), .busy(bz_o[2])
`ifdef PIXEL_PARSE_ERR_CNT_EN
    , .err_cnt(ec_o[2])
`endif
  );

  function automatic int dl(input int i);
    return (i == 0) ? 43 : (i == 1) ? 11 : 12;
  endfunction

  function automatic logic [7:0] dbyte(input int i, input int b);
    case (i)
      0:       return data43[b*8 +: 8];
      1:       return data11[b*8 +: 8];
      default: return data12[b*8 +: 8];
    endcase
  endfunction

  function automatic logic [7:0] flip();
    return 8'(32'd1 << $urandom_range(0, 7));
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
  endtask

  // Outputs are compared every cycle against the frame-level expectations.
  always @(negedge clk) begin
    if (run) begin
      for (int i = 0; i < 3; i++) begin
        logic edv, efe, eb;
        int   bad;
        edv = (cyc == exp_dv[i]);
        efe = (cyc == exp_fe[i]);
        eb  = (cyc >= busy_on[i]) && (cyc < busy_off[i]);
        chk($sformatf("data_valid[%0d]", i), 128'(dv_o[i]), 128'(edv));
        chk($sformatf("frame_err[%0d]", i), 128'(fe_o[i]), 128'(efe));
        chk($sformatf("busy[%0d]", i), 128'(bz_o[i]), 128'(eb));
        if (dv_o[i]) begin
          dv_cnt[i]++;
          bad = 0;
          for (int b = 0; b < dl(i); b++) begin
            if (dbyte(i, b) !== mb[i][b]) bad++;
          end
          chk($sformatf("data bytes wrong[%0d]", i), 128'(bad), 128'(0));
        end
`ifdef PIXEL_PARSE_ERR_CNT_EN
        if (efe) ec_model[i]++;
        chk($sformatf("err_cnt[%0d]", i), 128'(ec_o[i]), 128'(ec_model[i]));
`endif
      end
    end
  end

  task automatic drive_word(input int i, input logic [47:0] w, input bit gaps, output int p);
    int ng;
    ng = gaps ? int'($urandom_range(0, 2)) : 0;
    repeat (ng) begin
      @(posedge clk); #1;
      pv[i] = 1'b0;
      pw[i] = {$urandom, $urandom};
    end
    @(posedge clk); #1;
    pv[i] = 1'b1;
    pw[i] = {16'($urandom), w};
    p = cyc + 1;
  endtask

  task automatic idle(input int i, input int n);
    repeat (n) begin
      @(posedge clk); #1;
      pv[i] = 1'b0;
      pw[i] = {$urandom, $urandom};
    end
  endtask

  // mode: 0 good, 1 bad header, 2 bad AA/DD, 3 bad trailing DD, 4 SOF restart, 5 reset mid-payload
  task automatic send_frame(input int i, input int mode, input bit gaps, input bit fixed);
    int dlen, nf, rm, p, m;
    logic [47:0] hdr, w;
    logic [7:0] by;
    bit err;
    dlen = dl(i);
    nf   = dlen / 6;
    rm   = dlen % 6;
    m    = mode;
    err  = 1'b0;
    if (m == 3 && rm != 5) m = 2;
    hdr = {8'h00, 8'(dlen), 8'(dlen >> 8), 16'h0000, 8'h01};
    drive_word(i, SOF, gaps, p);
    busy_on[i]  = p;
    busy_off[i] = BIG;
    if (m == 4) begin
      drive_word(i, hdr, gaps, p);
      drive_word(i, SOF, gaps, p);
    end
    drive_word(i, hdr, gaps, p);
    if (m == 1) begin
      drive_word(i, {hdr[47:8], 8'h02}, gaps, p);
      err = 1'b1;
    end else begin
      drive_word(i, hdr, gaps, p);
      for (int j = 0; j < nf; j++) begin
        for (int b = 0; b < 6; b++) begin
          by = fixed ? 8'(j*6 + b + 16) : 8'($urandom);
          w[b*8 +: 8] = by;
          mb[i][j*6 + b] = by;
        end
        drive_word(i, w, gaps, p);
        if (m == 5 && j == 2) begin
          @(posedge clk); #1;
          rstn  = 1'b0;
          pv[i] = 1'b0;
          for (int q = 0; q < 3; q++) begin
            if (busy_off[q] > cyc) busy_off[q] = cyc;
            exp_dv[q]   = -1;
            exp_fe[q]   = -1;
            ec_model[q] = 0;
            for (int b = 0; b < 1024; b++) mb[q][b] = 8'h00;
          end
          #1;
          chk("busy drops at reset", 128'(bz_o[i]), 128'(0));
          chk("data cleared at reset", 128'(|data43), 128'(0));
          repeat (2) @(posedge clk);
          #1 rstn = 1'b1;
          idle(i, 2);
          return;
        end
      end
      w = {16'($urandom), 32'($urandom)};
      for (int b = 0; b < rm; b++) begin
        by = fixed ? 8'(nf*6 + b + 16) : 8'($urandom);
        w[b*8 +: 8] = by;
        mb[i][nf*6 + b] = by;
      end
      if (rm == 5) begin
        w[47:40] = (m == 2) ? (8'hAA ^ flip()) : 8'hAA;
        drive_word(i, w, gaps, p);
        if (m == 2) begin
          err = 1'b1;
        end else begin
          w = {16'($urandom), 32'($urandom)};
          w[7:0] = (m == 3) ? (8'hDD ^ flip()) : 8'hDD;
          drive_word(i, w, gaps, p);
          if (m == 3) err = 1'b1;
        end
      end else begin
        w[rm*8 +: 8]     = 8'hAA;
        w[(rm+1)*8 +: 8] = 8'hDD;
        if (m == 2) begin
          if ($urandom_range(0, 1) == 1) w[rm*8 +: 8] = 8'hAA ^ flip();
          else                           w[(rm+1)*8 +: 8] = 8'hDD ^ flip();
          err = 1'b1;
        end
        drive_word(i, w, gaps, p);
      end
    end
    if (err) begin
      exp_fe[i]   = p;
      busy_off[i] = p;
    end else begin
      exp_dv[i]   = p + 1;
      busy_off[i] = p + 1;
    end
    idle(i, 3 + int'($urandom_range(0, 3)));
  endtask

  initial begin
    int p;
    rstn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pv[i] = 1'b0;
      pw[i] = '0;
      exp_dv[i] = -1;
      exp_fe[i] = -1;
      busy_on[i] = 0;
      busy_off[i] = 0;
      ec_model[i] = 0;
      dv_cnt[i] = 0;
      for (int b = 0; b < 1024; b++) mb[i][b] = 8'h00;
    end
    #2;
    chk("reset data_valid", 128'(dv_o), 128'(0));
    chk("reset frame_err", 128'(fe_o), 128'(0));
    chk("reset busy", 128'(bz_o), 128'(0));
    chk("reset data43", 128'(|data43), 128'(0));
    chk("reset data11", 128'(data11), 128'(0));
    chk("reset data12", 128'(data12), 128'(0));
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    run = 1'b1;

    drive_word(0, 48'h0, 1'b0, p);
    drive_word(0, {8'h02, 24'h000000, 16'hFFEA}, 1'b0, p);
    drive_word(0, 48'h0000_0000_FFEA, 1'b0, p);
    drive_word(0, {$urandom, 16'($urandom)}, 1'b0, p);
    idle(0, 2);

    send_frame(0, 0, 1'b0, 1'b1);
    chk("nominal byte0", 128'(data43[7:0]), 128'(8'h10));
    chk("nominal byte41", 128'(data43[41*8 +: 8]), 128'(8'h39));
    chk("nominal byte42", 128'(data43[42*8 +: 8]), 128'(8'h3A));
    chk("nominal dv count", 128'(dv_cnt[0]), 128'(1));

    send_frame(1, 0, 1'b0, 1'b1);
    chk("rem5 data11", 128'(data11), 128'(88'h1A191817161514131211_10));
    send_frame(1, 3, 1'b0, 1'b0);
    send_frame(1, 2, 1'b0, 1'b0);
    send_frame(1, 0, 1'b1, 1'b0);

    send_frame(2, 0, 1'b0, 1'b1);
    chk("rem0 data12", 128'(data12), 128'(96'h1B1A19181716151413121110));
    send_frame(2, 4, 1'b1, 1'b0);

    send_frame(0, 1, 1'b0, 1'b0);
`ifdef PIXEL_PARSE_ERR_CNT_EN
    chk("err_cnt after bad header", 128'(ec_o[0]), 128'(1));
`endif
    send_frame(0, 0, 1'b1, 1'b0);
    repeat (3) send_frame(0, 0, 1'b1, 1'b0);
    send_frame(0, 4, 1'b1, 1'b0);

    send_frame(0, 5, 1'b1, 1'b0);
    send_frame(0, 0, 1'b1, 1'b0);

    dv_cnt[0] = 0;
    send_frame(0, 0, 1'b0, 1'b1);
    drive_word(0, 48'h0, 1'b0, p);
    drive_word(0, 48'h0, 1'b0, p);
    idle(0, 1);
    send_frame(0, 0, 1'b0, 1'b1);
    chk("repeat dv count", 128'(dv_cnt[0]), 128'(2));
    chk("repeat byte0", 128'(data43[7:0]), 128'(8'h10));
    chk("repeat byte42", 128'(data43[42*8 +: 8]), 128'(8'h3A));

    for (int n = 0; n < 40; n++) begin
      int ri;
      ri = int'($urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) begin
        drive_word(ri, {$urandom, 16'($urandom)}, 1'b1, p);
        idle(ri, 1);
      end
      send_frame(ri, int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), 1'b0);
    end

    idle(0, 4);
    run = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
